// File: rtl/y86_pkg.sv
// Shared encodings for the Y86-64 PIPE hazard controller: icodes, status codes,
// register-ID helpers and the halt state machine encoding.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [2:0] S_AOK = 3'd1;
    localparam logic [2:0] S_HLT = 3'd2;
    localparam logic [2:0] S_ADR = 3'd3;
    localparam logic [2:0] S_INS = 3'd4;

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        HALTED = 1'b1
    } hz_state_e;

    // RNONE is the all-ones register ID for a given register-ID width.
    function automatic logic [31:0] rnone(input int unsigned reg_w);
        return (32'd1 << reg_w) - 32'd1;
    endfunction

    // Only HLT/ADR/INS are exceptions; 0 and 5..7 behave as AOK.
    function automatic logic is_exc(input logic [2:0] s);
        return (s == S_HLT) || (s == S_ADR) || (s == S_INS);
    endfunction

endpackage

// File: rtl/y86_sat_counter.sv
// Saturating up-counter with synchronous reset and clear.
module y86_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q <= '0;
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/y86_hazard_ctrl_v2.sv
// Stage-control unit for the Y86-64 PIPE core: load-use/ret/mispredict handling, sticky halt,
// stall watchdog. Define HAZ_PERF_CNT_EN to add the perf_* event counters.
module y86_hazard_ctrl_v2
    import y86_pkg::*;
#(
    parameter int REG_W       = 4,
    parameter int NSRC        = 2,
    parameter int STALL_LIMIT = 64,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            D_icode,
    input  logic [NSRC*REG_W-1:0] d_src,
    input  logic [3:0]            E_icode,
    input  logic [REG_W-1:0]      E_dstM,
    input  logic                  e_Cnd,
    input  logic [3:0]            M_icode,
    input  logic [2:0]            m_stat,
    input  logic [2:0]            W_stat,
    output logic                  F_stall,
    output logic                  D_stall,
    output logic                  D_bubble,
    output logic                  E_bubble,
    output logic                  M_bubble,
    output logic                  W_stall,
    output logic                  set_cc,
    output logic                  halted,
    output logic [2:0]            halt_code,
    output logic                  deadlock,
    output hz_state_e             dbg_state
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]      perf_cycles,
    output logic [CNT_W-1:0]      perf_loaduse,
    output logic [CNT_W-1:0]      perf_mispred,
    output logic [CNT_W-1:0]      perf_ret
`endif
);

    localparam logic [REG_W-1:0] RNONE    = REG_W'(rnone(REG_W));
    localparam logic [CNT_W-1:0] WD_FINAL = CNT_W'(STALL_LIMIT - 1);

    hz_state_e        state;
    logic             src_hit;
    logic             load_use;
    logic             ret_p;
    logic             mispred;
    logic             exc_m;
    logic             exc_w;
    logic             wd_inc;
    logic [CNT_W-1:0] wd_cnt;

    always_comb begin
        src_hit = 1'b0;
        for (int k = 0; k < NSRC; k++) begin
            if (d_src[k*REG_W +: REG_W] == E_dstM) src_hit = 1'b1;
        end
    end

    assign load_use = ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ)) && (E_dstM != RNONE) && src_hit;
    assign ret_p    = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
    assign mispred  = (E_icode == I_JXX) && !e_Cnd;
    assign exc_m    = is_exc(m_stat);
    assign exc_w    = is_exc(W_stat);
    assign halted   = (state == HALTED);
    assign dbg_state = state;

    // Reset flushes D/E/M with bubbles and holds nothing.
    always_comb begin
        F_stall  = 1'b0;
        D_stall  = 1'b0;
        D_bubble = 1'b1;
        E_bubble = 1'b1;
        M_bubble = 1'b1;
        W_stall  = 1'b0;
        set_cc   = 1'b0;
        if (!rst) begin
            F_stall  = load_use | ret_p | halted;
            D_stall  = load_use | halted;
            D_bubble = mispred | (ret_p & ~load_use);
            E_bubble = mispred | load_use;
            M_bubble = exc_m | exc_w;
            W_stall  = exc_w | halted;
            set_cc   = (E_icode == I_OPQ) & ~exc_m & ~exc_w & ~halted;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            halt_code <= 3'd0;
        end else if ((state == RUN) && exc_w) begin
            state     <= HALTED;
            halt_code <= W_stat;
        end
    end

    // A halted core stalls F forever by design, so the watchdog holds rather than counts.
    assign wd_inc = F_stall & ~halted;

    y86_sat_counter #(.W(CNT_W)) u_wd_cnt (
        .clk (clk),
        .rst (rst),
        .clr (~F_stall),
        .inc (wd_inc),
        .q   (wd_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            deadlock <= 1'b0;
        end else if (wd_inc && (wd_cnt == WD_FINAL)) begin
            deadlock <= 1'b1;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    y86_sat_counter #(.W(CNT_W)) u_perf_cycles (
        .clk (clk), .rst (rst), .clr (1'b0), .inc (~halted), .q (perf_cycles)
    );
    y86_sat_counter #(.W(CNT_W)) u_perf_loaduse (
        .clk (clk), .rst (rst), .clr (1'b0), .inc (load_use & ~halted), .q (perf_loaduse)
    );
    y86_sat_counter #(.W(CNT_W)) u_perf_mispred (
        .clk (clk), .rst (rst), .clr (1'b0), .inc (mispred & ~halted), .q (perf_mispred)
    );
    y86_sat_counter #(.W(CNT_W)) u_perf_ret (
        .clk (clk), .rst (rst), .clr (1'b0), .inc (ret_p & ~halted), .q (perf_ret)
    );
`endif

endmodule

// File: tb/tb_y86_hazard_ctrl_v2.sv
// Scoreboard bench for y86_hazard_ctrl_v2: directed hazard scenarios plus randomized traffic.
module tb_y86_hazard_ctrl_v2;
    import y86_pkg::*;

    logic       clk;
    logic       rst;
    logic [3:0] D_icode;
    logic [7:0] d_src;
    logic [3:0] E_icode;
    logic [3:0] E_dstM;
    logic       e_Cnd;
    logic [3:0] M_icode;
    logic [2:0] m_stat;
    logic [2:0] W_stat;
    logic       F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc;
    logic       halted;
    logic [2:0] halt_code;
    logic       deadlock;
    hz_state_e  dbg_state;

    y86_hazard_ctrl_v2 dut (
        .clk       (clk),
        .rst       (rst),
        .D_icode   (D_icode),
        .d_src     (d_src),
        .E_icode   (E_icode),
        .E_dstM    (E_dstM),
        .e_Cnd     (e_Cnd),
        .M_icode   (M_icode),
        .m_stat    (m_stat),
        .W_stat    (W_stat),
        .F_stall   (F_stall),
        .D_stall   (D_stall),
        .D_bubble  (D_bubble),
        .E_bubble  (E_bubble),
        .M_bubble  (M_bubble),
        .W_stall   (W_stall),
        .set_cc    (set_cc),
        .halted    (halted),
        .halt_code (halt_code),
        .deadlock  (deadlock),
        .dbg_state (dbg_state)
    );

    // Clock / reset defaults
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: what the core should look like after all prior edges.
    bit       m_halted;
    bit [2:0] m_code;
    int       m_run;
    bit       m_dead;

    // Expected vector: {state, F, Ds, Db, Eb, Mb, Ws, cc, halted, code[2:0], deadlock}
    logic [12:0] exp_q[$];
    string       tag_q[$];
    int          checks;
    int          errors;

    // Drive one cycle of inputs, predict the outputs, advance the model across the edge.
    task automatic drive(input logic r, input logic [3:0] di, input logic [7:0] ds,
                         input logic [3:0] ei, input logic [3:0] edm, input logic cnd,
                         input logic [3:0] mi, input logic [2:0] ms, input logic [2:0] ws,
                         input string tag);
        bit lu, rt, mp, xm, xw;
        bit [6:0] ctl;
        @(posedge clk);
        #1;
        rst = r; D_icode = di; d_src = ds; E_icode = ei; E_dstM = edm;
        e_Cnd = cnd; M_icode = mi; m_stat = ms; W_stat = ws;
        lu = (ei == 4'd5 || ei == 4'd11) && edm != 4'hF && (edm == ds[3:0] || edm == ds[7:4]);
        rt = (di == 4'd9) || (ei == 4'd9) || (mi == 4'd9);
        mp = (ei == 4'd7) && !cnd;
        xm = (ms >= 3'd2) && (ms <= 3'd4);
        xw = (ws >= 3'd2) && (ws <= 3'd4);
        if (r) ctl = 7'b0011100;
        else ctl = {lu | rt | m_halted, lu | m_halted, mp | (rt & !lu), mp | lu,
                    xm | xw, xw | m_halted, (ei == 4'd6) && !xm && !xw && !m_halted};
        exp_q.push_back({m_halted, ctl, m_halted, m_code, m_dead});
        tag_q.push_back(tag);
        if (r) begin
            m_halted = 0; m_code = 0; m_run = 0; m_dead = 0;
        end else begin
            bit f;
            f = lu | rt | m_halted;
            if (!f) m_run = 0;
            else if (!m_halted) begin
                if (m_run < 65535) m_run++;
                if (m_run == 64) m_dead = 1;
            end
            if (!m_halted && xw) begin
                m_halted = 1;
                m_code = ws;
            end
        end
    endtask

    task automatic idle(input logic r, input string tag);
        drive(r, 4'd1, 8'hFF, 4'd1, 4'hF, 1'b1, 4'd1, 3'd1, 3'd1, tag);
    endtask

    task automatic rand_cycle();
        logic [7:0] ds;
        logic [3:0] edm;
        logic [2:0] ms, ws;
        ds  = 8'($urandom_range(0, 255));
        edm = ($urandom_range(0, 1) == 1) ? ds[4*$urandom_range(0, 1) +: 4] : 4'($urandom_range(0, 15));
        ms  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'd1;
        ws  = ($urandom_range(0, 39) == 0) ? 3'($urandom_range(0, 7)) : 3'd1;
        drive(($urandom_range(0, 49) == 0), 4'($urandom_range(0, 11)), ds,
              4'($urandom_range(0, 11)), edm, 1'($urandom_range(0, 1)),
              4'($urandom_range(0, 11)), ms, ws, "random");
    endtask

    // Monitor: outputs are combinational, so every cycle presents a response.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            logic [12:0] e, got;
            string t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            got = {dbg_state == HALTED, F_stall, D_stall, D_bubble, E_bubble, M_bubble,
                   W_stall, set_cc, halted, halt_code, deadlock};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL %s got=%b exp=%b t=%0t", t, got, e, $time);
            end
        end
    end

    initial begin
        checks = 0; errors = 0;
        m_halted = 0; m_code = 0; m_run = 0; m_dead = 0;
        rst = 1'b1; D_icode = 4'd1; d_src = 8'hFF; E_icode = 4'd1; E_dstM = 4'hF;
        e_Cnd = 1'b1; M_icode = 4'd1; m_stat = 3'd1; W_stat = 3'd1;

        idle(1, "reset"); idle(1, "reset"); idle(0, "idle");
        drive(0, 4'd1, 8'h3F, 4'd5, 4'h3, 1, 4'd1, 3'd1, 3'd1, "lu_port1");
        drive(0, 4'd1, 8'hF3, 4'd11, 4'h3, 1, 4'd1, 3'd1, 3'd1, "lu_pop_port0");
        drive(0, 4'd1, 8'hFF, 4'd5, 4'hF, 1, 4'd1, 3'd1, 3'd1, "lu_rnone");
        drive(0, 4'd1, 8'hFF, 4'd7, 4'hF, 0, 4'd1, 3'd1, 3'd1, "mispred");
        drive(0, 4'd9, 8'hFF, 4'd7, 4'hF, 0, 4'd1, 3'd1, 3'd1, "mispred_ret");
        drive(0, 4'd9, 8'h3F, 4'd5, 4'h3, 1, 4'd1, 3'd1, 3'd1, "lu_ret");
        drive(0, 4'd1, 8'hFF, 4'd6, 4'hF, 1, 4'd1, 3'd5, 3'd1, "opq_stat5");
        drive(0, 4'd1, 8'hFF, 4'd6, 4'hF, 1, 4'd1, 3'd2, 3'd1, "opq_mexc");
        drive(0, 4'd1, 8'hFF, 4'd1, 4'hF, 1, 4'd1, 3'd1, 3'd3, "halt_adr");
        for (int i = 0; i < 3; i++)
            drive(0, 4'd1, 8'hFF, 4'd6, 4'hF, 1, 4'd1, 3'd1, 3'd4, "halted_opq");
        idle(1, "halt_rst"); idle(0, "after_rst");

        // Watchdog: 64 stalled cycles trip it, a gap at cycle 63 does not.
        for (int i = 0; i < 66; i++) drive(0, 4'd9, 8'hFF, 4'd1, 4'hF, 1, 4'd1, 3'd1, 3'd1, "wd_trip");
        idle(1, "wd_rst"); idle(0, "wd_cleared");
        for (int i = 0; i < 70; i++) begin
            if (i == 62) idle(0, "wd_gap");
            else drive(0, 4'd9, 8'hFF, 4'd1, 4'hF, 1, 4'd1, 3'd1, 3'd1, "wd_no_trip");
        end
        idle(1, "rst"); idle(0, "idle");

        for (int i = 0; i < 3000; i++) rand_cycle();

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
